// File: rtl/usb_rx_ctrl_if.sv
// Bus between the USB receive front end (shift register, edge and EOP
// detectors) and the receive control unit, including the status outputs
// seen by the FIFO and the protocol layer.
interface usb_rx_ctrl_if #(
  parameter int CNT_W = 7
);
  // Front-end inputs to the controller
  logic             d_edge;
  logic             eop;
  logic             shift_enable;
  logic [7:0]       rcv_data;
  logic             byte_received;
  // Controller outputs
  logic             rcving;
  logic             w_enable;
  logic             r_error;
  logic [3:0]       pid;
  logic             pid_valid;
  logic [CNT_W-1:0] byte_count;
  logic [2:0]       err_code;
  logic             pkt_done;

  // Front end / environment side
  modport master (
    output d_edge, eop, shift_enable, rcv_data, byte_received,
    input  rcving, w_enable, r_error, pid, pid_valid, byte_count, err_code, pkt_done
  );

  // Receive controller side
  modport slave (
    input  d_edge, eop, shift_enable, rcv_data, byte_received,
    output rcving, w_enable, r_error, pid, pid_valid, byte_count, err_code, pkt_done
  );
endinterface

// File: rtl/usb_rx_ctrl.sv
// USB receive control unit: walks one packet from the first bus edge through
// SYNC check, PID capture and payload bytes to EOP, strobing the RX FIFO for
// each payload byte and reporting an encoded error cause.
module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_PATTERN = 8'b1000_0000,
  parameter int         MAX_PAYLOAD  = 64,
  parameter bit         CHECK_PID    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  usb_rx_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_SYNC = 3'd1;
  localparam logic [2:0] ERR_BAD_PID  = 3'd2;
  localparam logic [2:0] ERR_SHORT    = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;
  localparam logic [2:0] ERR_BAD_EOP  = 3'd5;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHK,
    PID_WAIT,
    PID_CHK,
    DATA_WAIT,
    STORE,
    EOP_2,
    DONE_WAIT,
    ERR_EOP,
    ERR_DLY,
    ERR_IDLE
  } state_t;

  state_t           state;
  logic [3:0]       pid_q;
  logic             pid_valid_q;
  logic [CNT_W-1:0] byte_count_q;
  logic [2:0]       err_code_q;
  logic             pkt_done_q;

  logic             rcving_d;
  logic             w_enable_d;
  logic             r_error_d;

  logic             se_eop;
  logic             se_j;

  // Byte counter never wraps, even if the overflow guard is ever bypassed.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Upper nibble of a PID byte must be the complement of the lower nibble.
  function automatic logic pid_bad(input logic [7:0] b);
    return CHECK_PID && (b[7:4] != ~b[3:0]);
  endfunction

  assign se_eop = bus.shift_enable && bus.eop;
  assign se_j   = bus.shift_enable && !bus.eop;

  // Packet sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pid_q        <= 4'h0;
      pid_valid_q  <= 1'b0;
      byte_count_q <= '0;
      err_code_q   <= ERR_NONE;
      pkt_done_q   <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.d_edge) begin
            state        <= SYNC_WAIT;
            byte_count_q <= '0;
            pid_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
          end
        end
        SYNC_WAIT: begin
          if (bus.byte_received) state <= SYNC_CHK;
        end
        SYNC_CHK: begin
          if (bus.rcv_data == SYNC_PATTERN) begin
            state <= PID_WAIT;
          end else begin
            err_code_q <= ERR_BAD_SYNC;
            state      <= ERR_EOP;
          end
        end
        PID_WAIT: begin
          if (bus.byte_received) begin
            state <= PID_CHK;
          end else if (se_eop) begin
            err_code_q <= ERR_SHORT;
            state      <= ERR_DLY;
          end
        end
        PID_CHK: begin
          if (pid_bad(bus.rcv_data)) begin
            err_code_q <= ERR_BAD_PID;
            state      <= ERR_EOP;
          end else begin
            pid_q       <= bus.rcv_data[3:0];
            pid_valid_q <= 1'b1;
            state       <= DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          // A byte arriving together with SE0 is taken as data.
          if (bus.byte_received) begin
            if (byte_count_q == MAX_CNT) begin
              err_code_q <= ERR_OVERFLOW;
              state      <= ERR_EOP;
            end else begin
              state <= STORE;
            end
          end else if (se_eop) begin
            state <= EOP_2;
          end
        end
        STORE: begin
          byte_count_q <= sat_inc(byte_count_q);
          state        <= DATA_WAIT;
        end
        EOP_2: begin
          if (se_eop) begin
            pkt_done_q <= 1'b1;
            state      <= DONE_WAIT;
          end else if (se_j) begin
            err_code_q <= ERR_BAD_EOP;
            state      <= ERR_IDLE;
          end
        end
        DONE_WAIT: begin
          if (bus.d_edge) state <= IDLE;
        end
        ERR_EOP: begin
          if (se_eop) state <= ERR_DLY;
        end
        ERR_DLY: begin
          if (bus.d_edge) state <= ERR_IDLE;
        end
        ERR_IDLE: begin
          if (bus.d_edge) begin
            state        <= SYNC_WAIT;
            byte_count_q <= '0;
            pid_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the bus-facing strobes from the state register alone.
  always_comb begin
    rcving_d   = 1'b1;
    w_enable_d = 1'b0;
    r_error_d  = 1'b0;
    case (state)
      IDLE, DONE_WAIT: rcving_d = 1'b0;
      STORE:           w_enable_d = 1'b1;
      ERR_EOP, ERR_DLY: r_error_d = 1'b1;
      ERR_IDLE: begin
        rcving_d  = 1'b0;
        r_error_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rcving     = rcving_d;
  assign bus.w_enable   = w_enable_d;
  assign bus.r_error    = r_error_d;
  assign bus.pid        = pid_q;
  assign bus.pid_valid  = pid_valid_q;
  assign bus.byte_count = byte_count_q;
  assign bus.err_code   = err_code_q;
  assign bus.pkt_done   = pkt_done_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Self-checking bench for usb_rx_ctrl. Three controllers share one stimulus:
// default parameters, a 4-byte payload limit, and PID checking disabled.
// Payload bytes expected at the default controller's FIFO strobe are queued
// when driven and compared when w_enable fires.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_enable = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       byte_received = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int wcnt0 = 0;
  int wcnt1 = 0;
  int done0 = 0;
  int w0_base;
  int w1_base;
  int d0_base;

  always #5 clk = ~clk;

  usb_rx_ctrl_if #(.CNT_W(7)) bus0 ();
  usb_rx_ctrl_if #(.CNT_W(3)) bus1 ();
  usb_rx_ctrl_if #(.CNT_W(7)) bus2 ();

  assign bus0.d_edge = d_edge;
  assign bus0.eop = eop;
  assign bus0.shift_enable = shift_enable;
  assign bus0.rcv_data = rcv_data;
  assign bus0.byte_received = byte_received;
  assign bus1.d_edge = d_edge;
  assign bus1.eop = eop;
  assign bus1.shift_enable = shift_enable;
  assign bus1.rcv_data = rcv_data;
  assign bus1.byte_received = byte_received;
  assign bus2.d_edge = d_edge;
  assign bus2.eop = eop;
  assign bus2.shift_enable = shift_enable;
  assign bus2.rcv_data = rcv_data;
  assign bus2.byte_received = byte_received;

  usb_rx_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus0));
  usb_rx_ctrl #(.MAX_PAYLOAD(4)) u_ovf (.clk(clk), .rst(rst), .bus(bus1));
  usb_rx_ctrl #(.CHECK_PID(1'b0)) u_nochk (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO-side monitor: pop the scoreboard on each write of the default unit.
  always @(negedge clk) begin
    if (bus0.w_enable === 1'b1) begin
      wcnt0++;
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else check("wr_data", bus0.rcv_data, exp_q.pop_front());
    end
    if (bus1.w_enable === 1'b1) wcnt1++;
    if (bus0.pkt_done === 1'b1) done0++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    d_edge = 1'b0;
    eop = 1'b0;
    shift_enable = 1'b0;
    byte_received = 1'b0;
    rcv_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    w0_base = wcnt0;
    w1_base = wcnt1;
    d0_base = done0;
  endtask

  task automatic pulse_edge();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push);
    if (push) exp_q.push_back(b);
    rcv_data = b;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
    tick();
    rcv_data = 8'h00;
    tick();
  endtask

  task automatic se0_sample();
    eop = 1'b1;
    shift_enable = 1'b1;
    tick();
    shift_enable = 1'b0;
    tick();
  endtask

  task automatic j_sample();
    eop = 1'b0;
    shift_enable = 1'b1;
    tick();
    shift_enable = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_rcving", bus0.rcving, 0);
    check("rst_w_enable", bus0.w_enable, 0);
    check("rst_r_error", bus0.r_error, 0);
    check("rst_pid", bus0.pid, 0);
    check("rst_pid_valid", bus0.pid_valid, 0);
    check("rst_byte_count", bus0.byte_count, 0);
    check("rst_err_code", bus0.err_code, 0);
    check("rst_pkt_done", bus0.pkt_done, 0);

    // Good packet: SYNC, PID C3, three data bytes, two SE0 samples, J
    pulse_edge();
    check("good_rcving_start", bus0.rcving, 1);
    send_byte(8'h80, 0);
    rcv_data = 8'hC3;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
    check("good_pid_valid_1cyc", bus0.pid_valid, 0);
    tick();
    check("good_pid_valid_2cyc", bus0.pid_valid, 1);
    check("good_pid", bus0.pid, 4'h3);
    rcv_data = 8'h00;
    tick();
    for (int i = 1; i <= 3; i++) send_byte(8'(8'h11 * i), 1);
    se0_sample();
    shift_enable = 1'b1;
    tick();
    shift_enable = 1'b0;
    check("good_pkt_done_pulse", bus0.pkt_done, 1);
    check("good_rcving_done_wait", bus0.rcving, 0);
    tick();
    check("good_pkt_done_clear", bus0.pkt_done, 0);
    check("good_byte_count", bus0.byte_count, 3);
    check("good_r_error", bus0.r_error, 0);
    check("good_err_code", bus0.err_code, 0);
    check("good_writes", wcnt0 - w0_base, 3);
    check("good_done_count", done0 - d0_base, 1);
    check("good_sb_empty", exp_q.size(), 0);
    eop = 1'b0;
    pulse_edge();
    check("good_hold_pid", bus0.pid, 4'h3);
    check("good_hold_count", bus0.byte_count, 3);
    check("good_hold_pid_valid", bus0.pid_valid, 1);

    // Bad SYNC
    do_reset();
    pulse_edge();
    rcv_data = 8'h81;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
    check("bsync_r_error_chk", bus0.r_error, 0);
    tick();
    rcv_data = 8'h00;
    check("bsync_r_error", bus0.r_error, 1);
    check("bsync_err_code", bus0.err_code, 1);
    se0_sample();
    check("bsync_dly_r_error", bus0.r_error, 1);
    check("bsync_dly_rcving", bus0.rcving, 1);
    eop = 1'b0;
    pulse_edge();
    check("bsync_idle_r_error", bus0.r_error, 1);
    check("bsync_idle_rcving", bus0.rcving, 0);
    pulse_edge();
    check("bsync_restart_r_error", bus0.r_error, 0);
    check("bsync_restart_err", bus0.err_code, 0);
    check("bsync_restart_rcving", bus0.rcving, 1);
    check("bsync_writes", wcnt0 - w0_base, 0);

    // PID check nibble
    do_reset();
    pulse_edge();
    send_byte(8'h80, 0);
    send_byte(8'hC4, 0);
    check("bpid_err_code", bus0.err_code, 2);
    check("bpid_pid_valid", bus0.pid_valid, 0);
    check("bpid_r_error", bus0.r_error, 1);
    check("nochk_pid_valid", bus2.pid_valid, 1);
    check("nochk_pid", bus2.pid, 4'h4);
    check("nochk_err_code", bus2.err_code, 0);

    // Payload overflow on the 4-byte unit
    do_reset();
    pulse_edge();
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 1);
    check("ovf_writes", wcnt1 - w1_base, 4);
    check("ovf_byte_count", bus1.byte_count, 4);
    check("ovf_err_code", bus1.err_code, 4);
    check("ovf_r_error", bus1.r_error, 1);
    check("ovf_default_count", bus0.byte_count, 5);
    check("ovf_sb_empty", exp_q.size(), 0);

    // SE0 after SYNC with no PID
    do_reset();
    pulse_edge();
    send_byte(8'h80, 0);
    se0_sample();
    check("short_err_code", bus0.err_code, 3);
    check("short_r_error", bus0.r_error, 1);

    // Single SE0 then J
    do_reset();
    pulse_edge();
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h5A, 1);
    se0_sample();
    j_sample();
    check("beop_err_code", bus0.err_code, 5);
    check("beop_rcving", bus0.rcving, 0);
    check("beop_r_error", bus0.r_error, 1);
    check("beop_no_done", done0 - d0_base, 0);
    check("beop_sb_empty", exp_q.size(), 0);

    // Handshake packet
    do_reset();
    pulse_edge();
    send_byte(8'h80, 0);
    send_byte(8'hD2, 0);
    se0_sample();
    se0_sample();
    check("hs_byte_count", bus0.byte_count, 0);
    check("hs_pid", bus0.pid, 4'h2);
    check("hs_pid_valid", bus0.pid_valid, 1);
    check("hs_done", done0 - d0_base, 1);
    check("hs_rcving", bus0.rcving, 0);

    // Reset during STORE after two data bytes
    do_reset();
    pulse_edge();
    send_byte(8'h80, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h11, 1);
    exp_q.push_back(8'h22);
    rcv_data = 8'h22;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
    check("mrst_in_store", bus0.w_enable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rcv_data = 8'h00;
    check("mrst_rcving", bus0.rcving, 0);
    check("mrst_w_enable", bus0.w_enable, 0);
    check("mrst_pid", bus0.pid, 0);
    check("mrst_pid_valid", bus0.pid_valid, 0);
    check("mrst_byte_count", bus0.byte_count, 0);
    check("mrst_err_code", bus0.err_code, 0);
    check("mrst_sb_empty", exp_q.size(), 0);
    pulse_edge();
    send_byte(8'h80, 0);
    send_byte(8'hE1, 0);
    send_byte(8'h44, 1);
    send_byte(8'h55, 1);
    se0_sample();
    se0_sample();
    check("mrst_next_count", bus0.byte_count, 2);
    check("mrst_next_pid", bus0.pid, 4'h1);
    check("mrst_next_r_error", bus0.r_error, 0);
    check("mrst_next_sb_empty", exp_q.size(), 0);
    eop = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
